// File: rtl/counter_up_down_mod.sv
// Modulo-(MAX_VAL+1) up/down counter with variable step, parallel load,
// registered terminal-count pulse and combinational limit flags.
// Optional feature: define COUNTER_SATURATE_EN to clamp at 0 / MAX_VAL instead of
// wrapping; tc then pulses after every edge on which a step was clipped.
module counter_up_down_mod #(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned MAX_VAL = 99,
    parameter int unsigned STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              direction,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              at_max,
    output logic              at_min
);

    // One guard bit above the wider of count and step, so out+s and out+mod-s never overflow.
    localparam int unsigned EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    localparam logic [EW-1:0]    MaxExt = EW'(MAX_VAL);
    localparam logic [EW-1:0]    ModExt = EW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);

    if (MAX_VAL < 1 || (64'(MAX_VAL) >> WIDTH) != 64'd0) begin : g_bad_max_val
        $error("MAX_VAL must lie in 1 .. 2**WIDTH-1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;

    logic [EW-1:0] step_ext;
    logic [EW-1:0] step_eff;
    logic [EW-1:0] out_ext;
    logic [EW-1:0] sum_up;
    logic [EW-1:0] up_next;
    logic [EW-1:0] dn_next;
    logic          up_over;
    logic          dn_under;

    // Effective step and candidate next values for both directions.
    always_comb begin
        step_ext = EW'(step);
        step_eff = (step_ext > MaxExt) ? MaxExt : step_ext;
        out_ext  = EW'(out_q);
        sum_up   = out_ext + step_eff;
        up_over  = sum_up > MaxExt;
        dn_under = step_eff > out_ext;
`ifdef COUNTER_SATURATE_EN
        up_next  = up_over  ? MaxExt : sum_up;
        dn_next  = dn_under ? '0     : out_ext - step_eff;
`else
        up_next  = up_over  ? sum_up - ModExt              : sum_up;
        dn_next  = dn_under ? out_ext + ModExt - step_eff  : out_ext - step_eff;
`endif
    end

    // Next-state selection: load beats enable; tc marks a wrap (or clip) only.
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        if (load) begin
            out_d = (load_val > MaxW) ? MaxW : load_val;
        end else if (enable) begin
            if (direction) begin
                out_d = WIDTH'(up_next);
                tc_d  = up_over;
            end else begin
                out_d = WIDTH'(dn_next);
                tc_d  = dn_under;
            end
        end
    end

    // State registers with synchronous reset overriding everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    // Outputs and limit flags.
    always_comb begin
        out    = out_q;
        tc     = tc_q;
        at_max = (out_q == MaxW);
        at_min = (out_q == '0);
    end

endmodule

// File: tb/tb_counter_up_down_mod.sv
// Self-checking bench for counter_up_down_mod (WIDTH=7, MAX_VAL=99, STEP_W=4).
// Follows COUNTER_SATURATE_EN so the same bench covers either build.
module tb_counter_up_down_mod;

    localparam int MAXV = 99;

    logic       clk = 1'b0;
    logic       rst, enable, direction, load;
    logic [6:0] load_val;
    logic [3:0] step;
    logic [6:0] out;
    logic       tc, at_max, at_min;

    counter_up_down_mod #(
        .WIDTH   (7),
        .MAX_VAL (MAXV),
        .STEP_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .direction (direction),
        .load      (load),
        .load_val  (load_val),
        .step      (step),
        .out       (out),
        .tc        (tc),
        .at_max    (at_max),
        .at_min    (at_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       ld;
        logic       en;
        logic       dir;
        logic [6:0] lv;
        logic [3:0] st;
        int         eo;
        int         et;
    } vec_t;

    typedef struct {
        int    out;
        int    tc;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic en, input logic dir,
                         input logic [6:0] lv, input logic [3:0] st);
        rst = r; load = ld; enable = en; direction = dir; load_val = lv; step = st;
    endtask

    task automatic push_exp(input int o, input int t, input string nm);
        exp_t e;
        e.out = o; e.tc = t; e.name = nm;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop the oldest expectation and compare.
    task automatic clock_and_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".out"}, int'(out), e.out);
            chk({e.name, ".tc"}, int'(tc), e.tc);
            chk({e.name, ".at_max"}, int'(at_max), int'(e.out == MAXV));
            chk({e.name, ".at_min"}, int'(at_min), int'(e.out == 0));
        end
    endtask

    task automatic add(input logic r, input logic ld, input logic en, input logic dir,
                       input logic [6:0] lv, input logic [3:0] st, input int eo, input int et);
        vec_t v;
        v.r = r; v.ld = ld; v.en = en; v.dir = dir; v.lv = lv; v.st = st; v.eo = eo; v.et = et;
        vecs.push_back(v);
    endtask

    int ref_out;
    int ref_tc;
    int t;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 4'd0);

        //   r  ld  en  dir lv      st     out tc
        add(1, 0, 0, 1, 7'd0,   4'd0,  0,  0);   // reset state
`ifdef COUNTER_SATURATE_EN
        add(0, 1, 0, 1, 7'd97,  4'd0,  97, 0);
        add(0, 0, 1, 1, 7'd0,   4'd5,  99, 1);   // clipped at top
        add(0, 0, 1, 1, 7'd0,   4'd5,  99, 1);   // repeated attempt at limit
        add(0, 1, 0, 0, 7'd4,   4'd0,  4,  0);
        add(0, 0, 1, 0, 7'd0,   4'd9,  0,  1);   // clipped at bottom
        add(0, 0, 1, 0, 7'd0,   4'd9,  0,  1);
        add(0, 0, 1, 0, 7'd0,   4'd0,  0,  0);   // zero step never clips
        add(0, 0, 1, 1, 7'd0,   4'd3,  3,  0);
        add(0, 0, 0, 1, 7'd0,   4'd3,  3,  0);   // hold
        add(0, 1, 1, 1, 7'd120, 4'd3,  99, 0);   // load clamps, beats enable
        add(1, 1, 1, 1, 7'd50,  4'd3,  0,  0);   // reset beats load
`else
        add(0, 1, 0, 1, 7'd95,  4'd0,  95, 0);
        add(0, 0, 1, 1, 7'd0,   4'd7,  2,  1);   // wrap up
        add(0, 0, 1, 1, 7'd0,   4'd7,  9,  0);
        add(0, 1, 0, 1, 7'd3,   4'd0,  3,  0);
        add(0, 0, 1, 0, 7'd0,   4'd5,  98, 1);   // wrap down
        add(0, 0, 0, 0, 7'd0,   4'd5,  98, 0);   // hold, tc drops
        add(0, 1, 1, 1, 7'd120, 4'd3,  99, 0);   // load clamps, beats enable
        add(0, 0, 1, 1, 7'd0,   4'd1,  0,  1);
        add(0, 0, 1, 1, 7'd0,   4'd2,  2,  0);
        add(1, 1, 1, 1, 7'd50,  4'd3,  0,  0);   // reset beats load mid-count
        add(0, 0, 1, 1, 7'd0,   4'd0,  0,  0);   // zero step holds
        add(0, 0, 1, 0, 7'd0,   4'd0,  0,  0);
        add(0, 0, 1, 0, 7'd0,   4'd15, 85, 1);
        add(0, 0, 1, 1, 7'd0,   4'd15, 0,  1);   // lands exactly on wrap to 0
        add(0, 0, 1, 1, 7'd0,   4'd15, 15, 0);
        add(0, 0, 1, 0, 7'd0,   4'd4,  11, 0);   // direction flip, no idle cycle
        add(0, 0, 1, 1, 7'd0,   4'd4,  15, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].ld, vecs[i].en, vecs[i].dir, vecs[i].lv, vecs[i].st);
            push_exp(vecs[i].eo, vecs[i].et, $sformatf("vec%0d", i));
            clock_and_check();
        end

        // Long run from reset: step 1 up for 101 cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 4'd0);
        push_exp(0, 0, "run_rst");
        clock_and_check();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 4'd1);
        for (int i = 0; i < 101; i++) begin
`ifdef COUNTER_SATURATE_EN
            push_exp((i + 1 > MAXV) ? MAXV : i + 1, int'(i + 1 > MAXV), $sformatf("run%0d", i));
`else
            push_exp((i + 1) % (MAXV + 1), int'(i == MAXV), $sformatf("run%0d", i));
`endif
            clock_and_check();
        end

        // Random traffic against an integer reference model.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 4'd0);
        push_exp(0, 0, "rnd_rst");
        clock_and_check();
        ref_out = 0;
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.r   = ($urandom_range(0, 49) == 0);
            v.ld  = ($urandom_range(0, 9) == 0);
            v.en  = ($urandom_range(0, 4) != 0);
            v.dir = $urandom_range(0, 1) != 0;
            v.lv  = 7'($urandom_range(0, 127));
            v.st  = 4'($urandom_range(0, 15));
            ref_tc = 0;
            if (v.r) begin
                ref_out = 0;
            end else if (v.ld) begin
                ref_out = (int'(v.lv) > MAXV) ? MAXV : int'(v.lv);
            end else if (v.en) begin
                t = v.dir ? ref_out + int'(v.st) : ref_out - int'(v.st);
`ifdef COUNTER_SATURATE_EN
                if (t > MAXV) begin ref_out = MAXV; ref_tc = 1; end
                else if (t < 0) begin ref_out = 0; ref_tc = 1; end
                else ref_out = t;
`else
                if (t > MAXV) begin ref_out = t - (MAXV + 1); ref_tc = 1; end
                else if (t < 0) begin ref_out = t + (MAXV + 1); ref_tc = 1; end
                else ref_out = t;
`endif
            end
            drive(v.r, v.ld, v.en, v.dir, v.lv, v.st);
            push_exp(ref_out, ref_tc, $sformatf("rnd%0d", i));
            clock_and_check();
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_up_down_mod.md
COUNTER_UP_DOWN_MOD -- requirements
Module: counter_up_down_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 7, counter width in bits.
REQ-002 SHALL have parameter MAX_VAL, default 99, highest count value (modulus = MAX_VAL+1); legal range 1..2^WIDTH-1.
REQ-003 SHALL have parameter STEP_W, default 4, width of the step input.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  count when high, hold when low.
REQ-007 SHALL have port direction  input  1  1 = count up, 0 = count down.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port step  input  STEP_W  increment/decrement amount per enabled cycle.
REQ-011 SHALL have port out  output  WIDTH  registered count.
REQ-012 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-013 SHALL have ports at_max, at_min  output  1 each  combinational: out==MAX_VAL, out==0.

Function
REQ-014 SHALL update out and tc only on rising clk; priority rst > load > enable.
REQ-015 SHALL, on load, set out to min(load_val, MAX_VAL) and tc to 0, regardless of enable/direction.
REQ-016 SHALL use effective step s = min(step, MAX_VAL); s==0 with enable high holds out and leaves tc 0.
REQ-017 SHALL, enabled and up: if out+s <= MAX_VAL then out <= out+s, else out <= out+s-(MAX_VAL+1) (wrap).
REQ-018 SHALL, enabled and down: if s <= out then out <= out-s, else out <= out+(MAX_VAL+1)-s (wrap).
REQ-019 SHALL compute sums/differences at WIDTH+1 bits so no intermediate overflow occurs for any legal MAX_VAL.
REQ-020 SHALL assert tc for exactly the one cycle following the clock edge on which a wrap occurred; tc is 0 on every other cycle.
REQ-021 SHALL hold out and drive tc 0 when enable is low and load is low.
REQ-022 SHALL never present out > MAX_VAL after the first reset.
REQ-023 SHALL, when direction changes between consecutive enabled cycles, apply the new direction on the next edge with no idle cycle.

Reset
REQ-024 SHALL, on rst high at a clock edge, set out=0 and tc=0, overriding load and enable, including mid-count.
REQ-025 SHALL resume normal operation on the first edge after rst deasserts; at_min=1 and at_max=0 while out=0.

Configuration
REQ-026 SHALL support macro COUNTER_SATURATE_EN; undefined: wrap behaviour per REQ-017/018/020.
REQ-027 SHALL, with COUNTER_SATURATE_EN defined, clamp instead of wrap: up stops at MAX_VAL, down stops at 0; tc pulses one cycle after each edge where a step was clipped (including repeated attempts while already at a limit).

Verification (WIDTH=7, MAX_VAL=99, STEP_W=4)
REQ-028 SHALL cover: rst, then enable=1 direction=1 step=1 for 101 cycles -> out 0..99,0,1; tc=1 only the cycle out first shows 0.
REQ-029 SHALL cover: load load_val=95, then up step=7 -> out=2, tc=1 one cycle; next step -> out=9, tc=0.
REQ-030 SHALL cover: load 3, direction=0 step=5 -> out=98, tc=1; enable=0 next -> out holds 98, tc=0.
REQ-031 SHALL cover: load=1 load_val=120 with enable=1 same cycle -> out=99, tc=0, at_max=1.
REQ-032 SHALL cover: rst=1 together with load=1 load_val=50 mid-count -> out=0, tc=0; step=0 enabled -> out stays 0.
REQ-033 SHALL cover (COUNTER_SATURATE_EN): load 97, up step=5 -> out=99, tc=1; repeat -> out=99, tc=1; down step=9 from 4 -> out=0, tc=1.
